// File: rtl/seq_detect_prog_if.sv
// seq_detect_prog_if
// Bundles the serial data, configuration and result signals of the
// programmable sequence detector.
//   master : drives a/valid, cfg_* and cnt_clr; observes out, match_cnt, cfg_err
//   slave  : the detector side of the same signals
interface seq_detect_prog_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 8
);
   logic               a;
   logic               valid;
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               cnt_clr;
   logic               out;
   logic [CNT_W-1:0]   match_cnt;
   logic               cfg_err;

   modport master (
      output a, valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
      input  out, match_cnt, cfg_err
   );

   modport slave (
      input  a, valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
      output out, match_cnt, cfg_err
   );
endinterface

// File: rtl/seq_detect_prog.sv
// seq_detect_prog
// Programmable serial bit-sequence detector. Matches the newest len bits of
// the received history against a runtime-loaded pattern, with overlapping or
// non-overlapping matching, valid qualification and a saturating match count.
// Reset configuration detects 10101 with overlap.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : seq_detect_prog_if.slave (a, valid, cfg_*, cnt_clr in;
//            out, match_cnt, cfg_err out, all registered)
module seq_detect_prog #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(5'b10101),
   parameter int                 RST_LEN     = 5,
   parameter bit                 RST_OVERLAP = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   seq_detect_prog_if.slave bus
);

   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;
   logic [MAX_LEN-1:0] pat;
   logic [LEN_W-1:0]   len;
   logic               ovl;
   logic               out_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               err_q;

   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-1:0] nh;
   logic [LEN_W-1:0]   nf;
   logic               match;
   logic               cfg_ok;
   logic               sample;

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
      nh     = {hist[MAX_LEN-2:0], bus.a};
      // fill saturates so a long run never wraps back below len
      nf     = (int'(fill) >= MAX_LEN) ? fill : fill + 1'b1;
      // only the low len bits take part; higher pattern/history bits are ignored
      match  = (nf >= len) && (((nh ^ pat) & mask) == '0);
      cfg_ok = (bus.cfg_len != '0) && (int'(bus.cfg_len) <= MAX_LEN);
      sample = bus.valid && !bus.cfg_we;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist  <= '0;
         fill  <= '0;
         pat   <= RST_PATTERN;
         len   <= LEN_W'(RST_LEN);
         ovl   <= RST_OVERLAP;
         out_q <= 1'b0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         out_q <= 1'b0;
         err_q <= 1'b0;
         if (bus.cfg_we) begin
            // the bit presented alongside a config write is always dropped
            if (cfg_ok) begin
               pat  <= bus.cfg_pattern;
               len  <= bus.cfg_len;
               ovl  <= bus.cfg_overlap;
               hist <= '0;
               fill <= '0;
            end else begin
               err_q <= 1'b1;
            end
         end else if (bus.valid) begin
            hist  <= nh;
            // non-overlapping: restart the fill count so the matched bits
            // cannot be reused by the next match
            fill  <= (!ovl && match) ? '0 : nf;
            out_q <= match;
         end

         if (bus.cnt_clr) begin
            cnt_q <= '0;
         end else if (sample && match && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign bus.out       = out_q;
   assign bus.match_cnt = cnt_q;
   assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog
// Directed bench for seq_detect_prog: a default-parameter instance and a
// CNT_W=2 instance for counter saturation.
module tb_seq_detect_prog;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(8)) bus  ();
   seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

   seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus drivers (no checking) ----------------
   task automatic cyc(input logic a_i, input logic v_i, input logic clr_i);
      bus.a       = a_i;
      bus.valid   = v_i;
      bus.cfg_we  = 1'b0;
      bus.cnt_clr = clr_i;
      @(posedge clk);
      #1;
      bus.valid   = 1'b0;
      bus.cnt_clr = 1'b0;
   endtask

   task automatic cfg_wr(input logic [7:0] p, input logic [3:0] l, input logic o,
                         input logic v_i, input logic a_i);
      bus.cfg_pattern = p;
      bus.cfg_len     = l;
      bus.cfg_overlap = o;
      bus.cfg_we      = 1'b1;
      bus.valid       = v_i;
      bus.a           = a_i;
      @(posedge clk);
      #1;
      bus.cfg_we      = 1'b0;
      bus.valid       = 1'b0;
   endtask

   task automatic cyc2(input logic a_i, input logic v_i, input logic clr_i);
      bus2.a       = a_i;
      bus2.valid   = v_i;
      bus2.cfg_we  = 1'b0;
      bus2.cnt_clr = clr_i;
      @(posedge clk);
      #1;
      bus2.valid   = 1'b0;
      bus2.cnt_clr = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      #3;
      checks++;
      if (bus.out !== 1'b0) begin
         errors++; $display("FAIL reset_out got %b exp 0", bus.out);
      end
      checks++;
      if (bus.match_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_cnt got %0d exp 0", bus.match_cnt);
      end
      checks++;
      if (bus.cfg_err !== 1'b0) begin
         errors++; $display("FAIL reset_err got %b exp 0", bus.cfg_err);
      end
      #20;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_default_overlap;
      logic [6:0] bits;
      logic [6:0] exp;
      bits = 7'b1010101;
      exp  = 7'b0000101;
      for (int i = 6; i >= 0; i--) begin
         cyc(bits[i], 1'b1, 1'b0);
         checks++;
         if (bus.out !== exp[i]) begin
            errors++; $display("FAIL dflt_out bit%0d got %b exp %b", 6 - i, bus.out, exp[i]);
         end
      end
      checks++;
      if (bus.match_cnt !== 8'd2) begin
         errors++; $display("FAIL dflt_cnt got %0d exp 2", bus.match_cnt);
      end
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.out !== 1'b0) begin
         errors++; $display("FAIL dflt_idle_out got %b exp 0", bus.out);
      end
   endtask

   task automatic test_nonoverlap;
      logic [10:0] bits;
      logic [10:0] exp;
      bits = 11'b1101101_1101;
      exp  = 11'b0001000_0001;
      cyc(1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.match_cnt !== 8'd0) begin
         errors++; $display("FAIL no_clr got %0d exp 0", bus.match_cnt);
      end
      cfg_wr(8'b0000_1101, 4'd4, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.cfg_err !== 1'b0) begin
         errors++; $display("FAIL no_cfg_err got %b exp 0", bus.cfg_err);
      end
      for (int i = 10; i >= 0; i--) begin
         cyc(bits[i], 1'b1, 1'b0);
         checks++;
         if (bus.out !== exp[i]) begin
            errors++; $display("FAIL no_out bit%0d got %b exp %b", 10 - i, bus.out, exp[i]);
         end
      end
      checks++;
      if (bus.match_cnt !== 8'd2) begin
         errors++; $display("FAIL no_cnt got %0d exp 2", bus.match_cnt);
      end
   endtask

   task automatic test_valid_gaps;
      logic [7:0] av;
      logic [7:0] vv;
      logic [7:0] exp;
      logic [3:0] bits;
      // cycle stream: 0v, idle, 0v, idle, idle, 1v, idle, 1v
      av  = 8'b0000_0101;
      vv  = 8'b1010_0101;
      exp = 8'b0000_0001;
      cfg_wr(8'b0000_0011, 4'd4, 1'b1, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         cyc(av[i], vv[i], 1'b0);
         checks++;
         if (bus.out !== exp[i]) begin
            errors++; $display("FAIL gap_out cyc%0d got %b exp %b", 7 - i, bus.out, exp[i]);
         end
      end
      bits = 4'b1100;
      for (int i = 3; i >= 0; i--) begin
         cyc(bits[i], 1'b1, 1'b0);
         checks++;
         if (bus.out !== 1'b0) begin
            errors++; $display("FAIL order_out bit%0d got %b exp 0", 3 - i, bus.out);
         end
      end
   endtask

   task automatic test_illegal_cfg;
      logic [4:0] bits;
      logic [4:0] exp;
      bits = 5'b10101;
      exp  = 5'b00001;
      cfg_wr(8'b0001_0101, 4'd5, 1'b1, 1'b0, 1'b0);
      cfg_wr(8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.cfg_err !== 1'b1) begin
         errors++; $display("FAIL ill0_err got %b exp 1", bus.cfg_err);
      end
      for (int i = 4; i >= 0; i--) begin
         cyc(bits[i], 1'b1, 1'b0);
         if (i == 4) begin
            checks++;
            if (bus.cfg_err !== 1'b0) begin
               errors++; $display("FAIL ill0_err_pulse got %b exp 0", bus.cfg_err);
            end
         end
         checks++;
         if (bus.out !== exp[i]) begin
            errors++; $display("FAIL ill0_out bit%0d got %b exp %b", 4 - i, bus.out, exp[i]);
         end
      end
      // 1,0 then rejected write carrying a=1 (dropped), then 1,0,1 completes 10101
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cfg_wr(8'h00, 4'd9, 1'b0, 1'b1, 1'b1);
      checks++;
      if (bus.cfg_err !== 1'b1) begin
         errors++; $display("FAIL ill9_err got %b exp 1", bus.cfg_err);
      end
      checks++;
      if (bus.out !== 1'b0) begin
         errors++; $display("FAIL ill9_wr_out got %b exp 0", bus.out);
      end
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.out !== 1'b1) begin
         errors++; $display("FAIL ill9_match got %b exp 1", bus.out);
      end
      // legal write with a matching bit alongside: bit must be discarded
      cfg_wr(8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (bus.out !== 1'b0) begin
         errors++; $display("FAIL we_valid_out got %b exp 0", bus.out);
      end
      cyc(1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.out !== 1'b0) begin
         errors++; $display("FAIL len1_zero got %b exp 0", bus.out);
      end
      cyc(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.out !== 1'b1) begin
         errors++; $display("FAIL len1_one got %b exp 1", bus.out);
      end
   endtask

   task automatic test_saturation;
      logic [1:0] exp_cnt;
      bus2.cfg_pattern = 8'h01;
      bus2.cfg_len     = 4'd1;
      bus2.cfg_overlap = 1'b1;
      bus2.cfg_we      = 1'b1;
      @(posedge clk);
      #1;
      bus2.cfg_we      = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         cyc2(1'b1, 1'b1, 1'b0);
         exp_cnt = (k >= 3) ? 2'd3 : 2'(k);
         checks++;
         if (bus2.out !== 1'b1) begin
            errors++; $display("FAIL sat_out k%0d got %b exp 1", k, bus2.out);
         end
         checks++;
         if (bus2.match_cnt !== exp_cnt) begin
            errors++; $display("FAIL sat_cnt k%0d got %0d exp %0d", k, bus2.match_cnt, exp_cnt);
         end
      end
      cyc2(1'b1, 1'b1, 1'b1);
      checks++;
      if (bus2.out !== 1'b1) begin
         errors++; $display("FAIL clr_out got %b exp 1", bus2.out);
      end
      checks++;
      if (bus2.match_cnt !== 2'd0) begin
         errors++; $display("FAIL clr_cnt got %0d exp 0", bus2.match_cnt);
      end
      cyc2(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus2.match_cnt !== 2'd1) begin
         errors++; $display("FAIL clr_next got %0d exp 1", bus2.match_cnt);
      end
   endtask

   task automatic test_reset_mid;
      logic [4:0] bits;
      logic [3:0] pre;
      bits = 5'b10101;
      pre  = 4'b1010;
      // segment 1: reset right after a match pulse
      cfg_wr(8'b0001_0101, 4'd5, 1'b1, 1'b0, 1'b0);
      for (int i = 4; i >= 0; i--) cyc(bits[i], 1'b1, 1'b0);
      checks++;
      if (bus.out !== 1'b1) begin
         errors++; $display("FAIL rm_pre_out got %b exp 1", bus.out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out !== 1'b0) begin
         errors++; $display("FAIL rm_async_out got %b exp 0", bus.out);
      end
      checks++;
      if (bus.match_cnt !== 8'd0) begin
         errors++; $display("FAIL rm_async_cnt got %0d exp 0", bus.match_cnt);
      end
      #10;
      rst_n = 1'b1;
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.out !== 1'b0) begin
         errors++; $display("FAIL rm_seg1_out got %b exp 0", bus.out);
      end
      // segment 2: reset after 1010 (reset config is 10101 overlapping)
      #2;
      rst_n = 1'b0;
      #10;
      rst_n = 1'b1;
      for (int i = 3; i >= 0; i--) cyc(pre[i], 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.match_cnt !== 8'd0) begin
         errors++; $display("FAIL rm2_cnt got %0d exp 0", bus.match_cnt);
      end
      #10;
      rst_n = 1'b1;
      cyc(1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.out !== 1'b0) begin
         errors++; $display("FAIL rm2_one_out got %b exp 0", bus.out);
      end
      for (int i = 3; i >= 0; i--) begin
         cyc(bits[i], 1'b1, 1'b0);
         checks++;
         if (bus.out !== (i == 0)) begin
            errors++; $display("FAIL rm2_full bit%0d got %b exp %b", 4 - i, bus.out, (i == 0));
         end
      end
      checks++;
      if (bus.match_cnt !== 8'd1) begin
         errors++; $display("FAIL rm2_full_cnt got %0d exp 1", bus.match_cnt);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.a = 1'b0;  bus.valid = 1'b0;  bus.cfg_we = 1'b0;  bus.cnt_clr = 1'b0;
      bus.cfg_pattern = '0;  bus.cfg_len = '0;  bus.cfg_overlap = 1'b0;
      bus2.a = 1'b0; bus2.valid = 1'b0; bus2.cfg_we = 1'b0; bus2.cnt_clr = 1'b0;
      bus2.cfg_pattern = '0; bus2.cfg_len = '0; bus2.cfg_overlap = 1'b0;

      test_reset();
      test_default_overlap();
      test_nonoverlap();
      test_valid_gaps();
      test_illegal_cfg();
      test_saturation();
      test_reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
